// File: rtl/e203_ifu_pcgen_ostd.sv
// e203_ifu_pcgen_ostd
// Fetch-PC generator that keeps up to OSTD_DEPTH fetch requests in flight.
// Redirects (EXU flush, BPU taken branch) mark older in-flight responses as
// stale. Those stale responses are drained silently. Surviving responses are
// forwarded to the IR stage together with the PC they were fetched from.
//
// Optional feature macro: E203_IFU_PCGEN_BYPASS_EN
//   defined   : a redirect target can be issued in the redirect cycle itself.
//   undefined : the redirect target is registered and issued one cycle later,
//               which keeps flush_pc/bjp_pc off the fetch-address path.
module e203_ifu_pcgen_ostd #(
  parameter int PC_SIZE     = 32,
  parameter int INSTR_SIZE  = 32,
  parameter int OSTD_DEPTH  = 2,
  parameter int FETCH_BYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_SIZE-1:0]    pc_rtvec,
  input  logic                  flush_req,
  input  logic [PC_SIZE-1:0]    flush_pc,
  output logic                  flush_ack,
  input  logic                  bjp_req,
  input  logic [PC_SIZE-1:0]    bjp_pc,
  input  logic                  halt_req,
  output logic                  halt_ack,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [PC_SIZE-1:0]    ifu_req_pc,
  output logic                  ifu_req_seq,
  input  logic                  ifu_rsp_valid,
  output logic                  ifu_rsp_ready,
  input  logic                  ifu_rsp_err,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic                  ifu_o_valid,
  input  logic                  ifu_o_ready,
  output logic [PC_SIZE-1:0]    ifu_o_pc,
  output logic [INSTR_SIZE-1:0] ifu_o_ir,
  output logic                  ifu_o_buserr
);

  // Pointer width is at least one bit so that OSTD_DEPTH=1 still elaborates.
  localparam int PTR_W = (OSTD_DEPTH > 1) ? $clog2(OSTD_DEPTH) : 1;
  localparam int CNT_W = $clog2(OSTD_DEPTH + 1);

  localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(OSTD_DEPTH - 1);
  localparam logic [CNT_W-1:0]   CNT_FULL  = CNT_W'(OSTD_DEPTH);
  localparam logic [PC_SIZE-1:0] GRAN_MASK = PC_SIZE'(FETCH_BYTES - 1);
  localparam logic [PC_SIZE-1:0] GRAN_STEP = PC_SIZE'(FETCH_BYTES);

  // ---------------------------------------------------------------------------
  // Architectural state
  // ---------------------------------------------------------------------------
  logic [PC_SIZE-1:0] pc_reg;        // PC of the last issued request
  logic               first_reg;     // first request after reset still pending
  logic               redir_reg;     // redirect seen but not yet issued
  logic [PC_SIZE-1:0] redir_pc_reg;  // target of that pending redirect

  // Tracking FIFO bookkeeping
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_next;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_next;

  // Per-slot views of the tracking FIFO, driven from the generate loop
  logic [PC_SIZE-1:0]    slot_pc   [OSTD_DEPTH];
  logic [OSTD_DEPTH-1:0] slot_kill;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic               redirect_now;
  logic [PC_SIZE-1:0] redir_tgt;
  logic               room;
  logic               req_allow;
  logic               push;
  logic               pop;
  logic               head_stale;
  logic [PC_SIZE-1:0] next_pc;
  logic               next_seq;

  // A flush always wins over a branch redirect in the same cycle.
  assign redirect_now = flush_req | bjp_req;
  assign redir_tgt    = flush_req ? flush_pc : bjp_pc;
  assign flush_ack    = flush_req;

  assign room = (cnt_reg < CNT_FULL);

`ifdef E203_IFU_PCGEN_BYPASS_EN
  assign req_allow = ~halt_req & room;
`else
  // The redirect cycle never issues, so the target only reaches the fetch
  // address through redir_pc_reg.
  assign req_allow = ~halt_req & room & ~redirect_now;
`endif

  // Outputs are held low while reset is asserted, regardless of the other inputs.
  assign ifu_req_valid = rst_n & req_allow;
  assign push          = ifu_req_valid & ifu_req_ready;

  // Select the next fetch address by redirect priority; bit0 is always cleared.
  always_comb begin
    next_pc  = (pc_reg & ~GRAN_MASK) + GRAN_STEP;
    next_seq = 1'b1;
`ifdef E203_IFU_PCGEN_BYPASS_EN
    if (redirect_now) begin
      next_pc  = redir_tgt;
      next_seq = 1'b0;
    end else if (redir_reg) begin
`else
    if (redir_reg) begin
`endif
      next_pc  = redir_pc_reg;
      next_seq = 1'b0;
    end else if (first_reg) begin
      next_pc  = pc_rtvec;
      next_seq = 1'b0;
    end
    next_pc[0] = 1'b0;
  end

  assign ifu_req_pc  = next_pc;
  assign ifu_req_seq = next_seq;

  // ---------------------------------------------------------------------------
  // Response path: zero latency, no buffering
  // ---------------------------------------------------------------------------
  assign head_stale    = slot_kill[rd_ptr_reg];
  assign ifu_o_valid   = rst_n & ifu_rsp_valid & ~head_stale;
  assign ifu_rsp_ready = head_stale | ifu_o_ready;
  assign ifu_o_pc      = slot_pc[rd_ptr_reg];
  assign ifu_o_ir      = ifu_rsp_instr;
  assign ifu_o_buserr  = ifu_rsp_err;

  // The count guard keeps an illegal response on an empty FIFO from underflowing it.
  assign pop = ifu_rsp_valid & ifu_rsp_ready & (cnt_reg != '0);

  assign halt_ack = rst_n & halt_req & (cnt_reg == '0) & ~redirect_now;

  // Advance the FIFO pointers with explicit wrap and track the occupancy.
  always_comb begin
    cnt_next    = cnt_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push) begin
      wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + CNT_W'(1);
      2'b01:   cnt_next = cnt_reg - CNT_W'(1);
      default: cnt_next = cnt_reg;
    endcase
  end

  // Fetch PC, redirect bookkeeping and FIFO pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg       <= '0;
      first_reg    <= 1'b1;
      redir_reg    <= 1'b0;
      redir_pc_reg <= '0;
      cnt_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (push) begin
        // An issued request consumes any pending redirect or the reset vector.
        pc_reg    <= ifu_req_pc;
        first_reg <= 1'b0;
        redir_reg <= 1'b0;
      end else if (redirect_now) begin
        // Remember the target; a later redirect simply overwrites it.
        redir_reg    <= 1'b1;
        redir_pc_reg <= redir_tgt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tracking FIFO slots: {pc, kill} per outstanding request
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < OSTD_DEPTH; gi++) begin : g_slot
    logic [PC_SIZE-1:0] slot_pc_reg;
    logic               slot_kill_reg;
    logic               slot_vld_reg;
    logic               slot_wr;
    logic               slot_rd;

    assign slot_wr = push & (wr_ptr_reg == PTR_W'(gi));
    assign slot_rd = pop  & (rd_ptr_reg == PTR_W'(gi));

    // Fill on push; a redirect kills only slots that were already occupied.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_pc_reg   <= '0;
        slot_kill_reg <= 1'b0;
        slot_vld_reg  <= 1'b0;
      end else if (slot_wr) begin
        // A request pushed in the redirect cycle is the redirect target itself, so it stays live.
        slot_pc_reg   <= ifu_req_pc;
        slot_kill_reg <= 1'b0;
        slot_vld_reg  <= 1'b1;
      end else begin
        if (slot_rd) begin
          slot_vld_reg <= 1'b0;
        end
        if (redirect_now && slot_vld_reg) begin
          slot_kill_reg <= 1'b1;
        end
      end
    end

    assign slot_pc[gi]   = slot_pc_reg;
    assign slot_kill[gi] = slot_kill_reg;
  end

  // Responses return in order against issued requests, so one with nothing outstanding is a bus bug.
  a_no_rsp_when_empty: assert property (
    @(posedge clk) disable iff (!rst_n) !(ifu_rsp_valid && (cnt_reg == '0))
  );

endmodule

// File: tb/tb_e203_ifu_pcgen_ostd.sv
// Testbench for e203_ifu_pcgen_ostd. A reference model keeps the address of the
// next fetch and a queue of outstanding requests with a stale flag.
// Directed scenarios are followed by a randomized run.
module tb_e203_ifu_pcgen_ostd;
  localparam int PC_SIZE     = 32;
  localparam int INSTR_SIZE  = 32;
  localparam int OSTD_DEPTH  = 2;
  localparam int FETCH_BYTES = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [PC_SIZE-1:0]    pc_rtvec = '0;
  logic                  flush_req = 1'b0;
  logic [PC_SIZE-1:0]    flush_pc = '0;
  logic                  flush_ack;
  logic                  bjp_req = 1'b0;
  logic [PC_SIZE-1:0]    bjp_pc = '0;
  logic                  halt_req = 1'b0;
  logic                  halt_ack;
  logic                  ifu_req_valid;
  logic                  ifu_req_ready = 1'b0;
  logic [PC_SIZE-1:0]    ifu_req_pc;
  logic                  ifu_req_seq;
  logic                  ifu_rsp_valid = 1'b0;
  logic                  ifu_rsp_ready;
  logic                  ifu_rsp_err = 1'b0;
  logic [INSTR_SIZE-1:0] ifu_rsp_instr = '0;
  logic                  ifu_o_valid;
  logic                  ifu_o_ready = 1'b0;
  logic [PC_SIZE-1:0]    ifu_o_pc;
  logic [INSTR_SIZE-1:0] ifu_o_ir;
  logic                  ifu_o_buserr;

  int checks = 0;
  int failures = 0;

  // Reference model state
  typedef struct {
    logic [31:0] pc;
    bit          stale;
  } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_next_pc;
  bit          m_next_seq;

  // Expectations for the current cycle
  bit          e_req_valid;
  logic [31:0] e_req_pc;
  bit          e_req_seq;
  bit          e_halt_ack;
  bit          e_o_valid;
  bit          e_rsp_ready;
  logic [31:0] e_o_pc;

  e203_ifu_pcgen_ostd #(
    .PC_SIZE(PC_SIZE), .INSTR_SIZE(INSTR_SIZE),
    .OSTD_DEPTH(OSTD_DEPTH), .FETCH_BYTES(FETCH_BYTES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_rtvec(pc_rtvec),
    .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(flush_ack),
    .bjp_req(bjp_req), .bjp_pc(bjp_pc),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_pc(ifu_req_pc), .ifu_req_seq(ifu_req_seq),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rsp_err(ifu_rsp_err), .ifu_rsp_instr(ifu_rsp_instr),
    .ifu_o_valid(ifu_o_valid), .ifu_o_ready(ifu_o_ready),
    .ifu_o_pc(ifu_o_pc), .ifu_o_ir(ifu_o_ir), .ifu_o_buserr(ifu_o_buserr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_next_pc     = pc_rtvec;
    m_next_pc[0]  = 1'b0;
    m_next_seq    = 1'b0;
  endtask

  // Derive this cycle's expected outputs from the model and the current inputs.
  task automatic calc_exp();
    bit          redir;
    logic [31:0] tgt;
    redir  = flush_req | bjp_req;
    tgt    = flush_req ? flush_pc : bjp_pc;
    tgt[0] = 1'b0;
`ifdef E203_IFU_PCGEN_BYPASS_EN
    e_req_valid = !halt_req && (m_q.size() < OSTD_DEPTH);
    e_req_pc    = redir ? tgt : m_next_pc;
    e_req_seq   = redir ? 1'b0 : m_next_seq;
`else
    e_req_valid = !halt_req && (m_q.size() < OSTD_DEPTH) && !redir;
    e_req_pc    = m_next_pc;
    e_req_seq   = m_next_seq;
`endif
    e_halt_ack  = halt_req && (m_q.size() == 0) && !redir;
    if (m_q.size() > 0) begin
      e_o_valid   = ifu_rsp_valid && !m_q[0].stale;
      e_rsp_ready = m_q[0].stale || ifu_o_ready;
      e_o_pc      = m_q[0].pc;
    end else begin
      e_o_valid   = 1'b0;
      e_rsp_ready = 1'b0;
      e_o_pc      = '0;
    end
  endtask

  // Apply the clock edge to the model.
  task automatic commit();
    bit          redir;
    bit          hs;
    bit          pop;
    logic [31:0] tgt;
    ent_t        tmp;
    redir  = flush_req | bjp_req;
    tgt    = flush_req ? flush_pc : bjp_pc;
    tgt[0] = 1'b0;
    hs     = e_req_valid && ifu_req_ready;
    pop    = ifu_rsp_valid && (m_q.size() > 0) && e_rsp_ready;
    if (pop) tmp = m_q.pop_front();
    if (redir) foreach (m_q[i]) m_q[i].stale = 1'b1;
    if (hs) begin
      m_q.push_back('{pc: e_req_pc, stale: 1'b0});
      m_next_pc  = (e_req_pc & ~32'(FETCH_BYTES - 1)) + 32'(FETCH_BYTES);
      m_next_seq = 1'b1;
    end else if (redir) begin
      m_next_pc  = tgt;
      m_next_seq = 1'b0;
    end
  endtask

  // Advance one clock: inputs are driven after the falling edge.
  task automatic step();
    calc_exp();
    @(posedge clk);
    commit();
    @(negedge clk);
  endtask

  task automatic set_idle();
    flush_req     = 1'b0;
    bjp_req       = 1'b0;
    halt_req      = 1'b0;
    ifu_req_ready = 1'b1;
    ifu_rsp_valid = 1'b0;
    ifu_o_ready   = 1'b1;
    ifu_rsp_err   = 1'b0;
    ifu_rsp_instr = $urandom;
  endtask

  // Halt new fetches and return every outstanding response.
  task automatic drain();
    int n;
    n = 0;
    set_idle();
    halt_req = 1'b1;
    while (m_q.size() > 0 && n < 20) begin
      ifu_rsp_valid = 1'b1;
      ifu_rsp_instr = $urandom;
      step();
      n++;
    end
    ifu_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    pc_rtvec      = 32'h8000_0000;
    halt_req      = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_o_ready   = 1'b1;
    ifu_req_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ifu_req_valid !== 1'b0 || ifu_o_valid !== 1'b0 || halt_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got req_valid=%b o_valid=%b halt_ack=%b exp 0 0 0",
               ifu_req_valid, ifu_o_valid, halt_ack);
    end
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_seq_fetch();
    logic [31:0] exp_pc [3];
    bit          exp_seq[3];
    exp_pc[0] = 32'h8000_0000; exp_seq[0] = 1'b0;
    exp_pc[1] = 32'h8000_0004; exp_seq[1] = 1'b1;
    exp_pc[2] = 32'h8000_0008; exp_seq[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifu_rsp_valid = (m_q.size() > 0);
      ifu_rsp_instr = $urandom;
      #1;
      checks++;
      if (ifu_req_valid !== 1'b1 || ifu_req_pc !== exp_pc[i] || ifu_req_seq !== exp_seq[i]) begin
        failures++;
        $display("FAIL seq_fetch[%0d] got valid=%b pc=%h seq=%b exp valid=1 pc=%h seq=%b",
                 i, ifu_req_valid, ifu_req_pc, ifu_req_seq, exp_pc[i], exp_seq[i]);
      end
      if (i == 1) begin
        checks++;
        if (ifu_o_valid !== 1'b1 || ifu_o_pc !== 32'h8000_0000) begin
          failures++;
          $display("FAIL seq_rsp got o_valid=%b o_pc=%h exp 1 80000000", ifu_o_valid, ifu_o_pc);
        end
      end
      step();
    end
    drain();
    $display("test_seq_fetch done");
  endtask

  task automatic test_ostd_limit();
    int hs;
    hs = 0;
    drain();
    set_idle();
    for (int i = 0; i < 5; i++) begin
      #1;
      if (ifu_req_valid && ifu_req_ready) hs++;
      step();
    end
    checks++;
    if (hs != OSTD_DEPTH) begin
      failures++;
      $display("FAIL ostd_handshakes got=%0d exp=%0d", hs, OSTD_DEPTH);
    end
    ifu_rsp_valid = 1'b1;
    #1;
    checks++;
    if (ifu_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL ostd_full_valid got=%b exp=0", ifu_req_valid);
    end
    step();
    ifu_rsp_valid = 1'b0;
    #1;
    checks++;
    if (ifu_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL ostd_reopen_valid got=%b exp=1", ifu_req_valid);
    end
    step();
    drain();
    $display("test_ostd_limit done");
  endtask

  task automatic test_flush_drain();
    drain();
    set_idle();
    step();
    step();
    flush_req = 1'b1;
    flush_pc  = 32'h0000_0100;
    #1;
    checks++;
    if (flush_ack !== 1'b1 || ifu_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_cycle got ack=%b req_valid=%b exp 1 0", flush_ack, ifu_req_valid);
    end
    step();
    flush_req     = 1'b0;
    ifu_rsp_valid = 1'b1;
    ifu_o_ready   = 1'b0;
    #1;
    checks++;
    if (ifu_o_valid !== 1'b0 || ifu_rsp_ready !== 1'b1 || ifu_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_stale0 got o_valid=%b rsp_ready=%b req_valid=%b exp 0 1 0",
               ifu_o_valid, ifu_rsp_ready, ifu_req_valid);
    end
    step();
    #1;
    checks++;
    if (ifu_o_valid !== 1'b0 || ifu_rsp_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_stale1 got o_valid=%b rsp_ready=%b exp 0 1", ifu_o_valid, ifu_rsp_ready);
    end
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h100 || ifu_req_seq !== 1'b0) begin
      failures++;
      $display("FAIL flush_target got valid=%b pc=%h seq=%b exp 1 00000100 0",
               ifu_req_valid, ifu_req_pc, ifu_req_seq);
    end
    step();
    halt_req    = 1'b1;
    ifu_o_ready = 1'b1;
    #1;
    checks++;
    if (ifu_o_valid !== 1'b1 || ifu_o_pc !== 32'h100) begin
      failures++;
      $display("FAIL flush_fwd got o_valid=%b o_pc=%h exp 1 00000100", ifu_o_valid, ifu_o_pc);
    end
    step();
    set_idle();
    flush_req = 1'b1;
    flush_pc  = 32'h0000_0140;
`ifdef E203_IFU_PCGEN_BYPASS_EN
    #1;
`else
    #1;
    checks++;
    if (ifu_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_lat_cycle0 got valid=%b exp 0", ifu_req_valid);
    end
    step();
    flush_req = 1'b0;
    #1;
`endif
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h140 || ifu_req_seq !== 1'b0) begin
      failures++;
      $display("FAIL flush_latency got valid=%b pc=%h seq=%b exp 1 00000140 0",
               ifu_req_valid, ifu_req_pc, ifu_req_seq);
    end
    step();
    drain();
    $display("test_flush_drain done");
  endtask

  task automatic test_flush_bjp_prio();
    drain();
    set_idle();
    flush_req = 1'b1;
    flush_pc  = 32'h0000_0300;
    bjp_req   = 1'b1;
    bjp_pc    = 32'h0000_0200;
    #1;
    checks++;
    if (flush_ack !== 1'b1) begin
      failures++;
      $display("FAIL prio_ack got=%b exp=1", flush_ack);
    end
`ifndef E203_IFU_PCGEN_BYPASS_EN
    step();
    flush_req = 1'b0;
    bjp_req   = 1'b0;
    #1;
`endif
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h300) begin
      failures++;
      $display("FAIL prio_target got valid=%b pc=%h exp 1 00000300", ifu_req_valid, ifu_req_pc);
    end
    step();
    drain();
    $display("test_flush_bjp_prio done");
  endtask

  task automatic test_halt();
    drain();
    set_idle();
    step();
    halt_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (halt_ack !== 1'b0 || ifu_req_valid !== 1'b0) begin
        failures++;
        $display("FAIL halt_wait[%0d] got ack=%b req_valid=%b exp 0 0", i, halt_ack, ifu_req_valid);
      end
      step();
    end
    ifu_rsp_valid = 1'b1;
    #1;
    checks++;
    if (halt_ack !== 1'b0) begin
      failures++;
      $display("FAIL halt_pop_cycle got ack=%b exp=0", halt_ack);
    end
    step();
    ifu_rsp_valid = 1'b0;
    #1;
    checks++;
    if (halt_ack !== 1'b1 || ifu_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_ack got ack=%b req_valid=%b exp 1 0", halt_ack, ifu_req_valid);
    end
    step();
    $display("test_halt done");
  endtask

  task automatic test_wrap_buserr();
    bit found;
    found = 1'b0;
    drain();
    set_idle();
    flush_req = 1'b1;
    flush_pc  = 32'hFFFF_FFFC;
    for (int i = 0; i < 4 && !found; i++) begin
      #1;
      calc_exp();
      if (e_req_valid && e_req_pc == 32'hFFFF_FFFC) found = 1'b1;
      step();
      flush_req = 1'b0;
    end
    #1;
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h0 || ifu_req_seq !== 1'b1) begin
      failures++;
      $display("FAIL wrap_pc got valid=%b pc=%h seq=%b exp 1 00000000 1",
               ifu_req_valid, ifu_req_pc, ifu_req_seq);
    end
    step();
    halt_req      = 1'b1;
    ifu_rsp_valid = 1'b1;
    ifu_rsp_err   = 1'b1;
    #1;
    checks++;
    if (ifu_o_valid !== 1'b1 || ifu_o_buserr !== 1'b1 || ifu_o_pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL buserr got o_valid=%b err=%b pc=%h exp 1 1 fffffffc",
               ifu_o_valid, ifu_o_buserr, ifu_o_pc);
    end
    step();
    ifu_rsp_err = 1'b0;
    #1;
    checks++;
    if (ifu_o_valid !== 1'b1 || ifu_o_buserr !== 1'b0 || ifu_o_pc !== 32'h0) begin
      failures++;
      $display("FAIL wrap_rsp got o_valid=%b err=%b pc=%h exp 1 0 00000000",
               ifu_o_valid, ifu_o_buserr, ifu_o_pc);
    end
    step();
    ifu_rsp_valid = 1'b0;
    $display("test_wrap_buserr done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      flush_req     = ($urandom_range(0, 9) == 0);
      flush_pc      = $urandom;
      bjp_req       = ($urandom_range(0, 7) == 0);
      bjp_pc        = $urandom;
      halt_req      = ($urandom_range(0, 5) == 0);
      ifu_req_ready = ($urandom_range(0, 3) != 0);
      ifu_rsp_valid = (m_q.size() > 0) && ($urandom_range(0, 1) == 1);
      ifu_o_ready   = ($urandom_range(0, 3) != 0);
      ifu_rsp_err   = ($urandom_range(0, 7) == 0);
      ifu_rsp_instr = $urandom;
      #1;
      calc_exp();
      checks++;
      if (ifu_req_valid !== e_req_valid) begin
        failures++;
        $display("FAIL rand_req_valid[%0d] got=%b exp=%b", n, ifu_req_valid, e_req_valid);
      end
      if (e_req_valid) begin
        checks++;
        if (ifu_req_pc !== e_req_pc || ifu_req_seq !== e_req_seq) begin
          failures++;
          $display("FAIL rand_req_pc[%0d] got pc=%h seq=%b exp pc=%h seq=%b",
                   n, ifu_req_pc, ifu_req_seq, e_req_pc, e_req_seq);
        end
      end
      checks++;
      if (halt_ack !== e_halt_ack || flush_ack !== flush_req) begin
        failures++;
        $display("FAIL rand_acks[%0d] got halt=%b flush=%b exp halt=%b flush=%b",
                 n, halt_ack, flush_ack, e_halt_ack, flush_req);
      end
      checks++;
      if (ifu_o_valid !== e_o_valid) begin
        failures++;
        $display("FAIL rand_o_valid[%0d] got=%b exp=%b", n, ifu_o_valid, e_o_valid);
      end
      if (e_o_valid) begin
        checks++;
        if (ifu_o_pc !== e_o_pc || ifu_o_ir !== ifu_rsp_instr || ifu_o_buserr !== ifu_rsp_err) begin
          failures++;
          $display("FAIL rand_o_data[%0d] got pc=%h ir=%h err=%b exp pc=%h ir=%h err=%b",
                   n, ifu_o_pc, ifu_o_ir, ifu_o_buserr, e_o_pc, ifu_rsp_instr, ifu_rsp_err);
        end
      end
      if (m_q.size() > 0) begin
        checks++;
        if (ifu_rsp_ready !== e_rsp_ready) begin
          failures++;
          $display("FAIL rand_rsp_ready[%0d] got=%b exp=%b", n, ifu_rsp_ready, e_rsp_ready);
        end
      end
      step();
    end
    $display("test_random done");
  endtask

  task automatic test_reset_midop();
    set_idle();
    step();
    step();
    #2;
    ifu_rsp_valid = 1'b1;
    rst_n         = 1'b0;
    #1;
    checks++;
    if (ifu_req_valid !== 1'b0 || ifu_o_valid !== 1'b0) begin
      failures++;
      $display("FAIL midop_reset got req_valid=%b o_valid=%b exp 0 0", ifu_req_valid, ifu_o_valid);
    end
    pc_rtvec = 32'h2000_0040;
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++;
    if (ifu_req_valid !== 1'b1 || ifu_req_pc !== 32'h2000_0040 || ifu_req_seq !== 1'b0) begin
      failures++;
      $display("FAIL midop_first got valid=%b pc=%h seq=%b exp 1 20000040 0",
               ifu_req_valid, ifu_req_pc, ifu_req_seq);
    end
    step();
    #1;
    checks++;
    if (ifu_req_pc !== 32'h2000_0044 || ifu_req_seq !== 1'b1) begin
      failures++;
      $display("FAIL midop_second got pc=%h seq=%b exp 20000044 1", ifu_req_pc, ifu_req_seq);
    end
    step();
    $display("test_reset_midop done");
  endtask

  initial begin
    test_reset();
    test_seq_fetch();
    test_ostd_limit();
    test_flush_drain();
    test_flush_bjp_prio();
    test_halt();
    test_wrap_buserr();
    test_random();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
